// File: rtl/uart_bus2mem.sv
// Bridges a pipelined address/data-phase bus onto a single-cycle SRAM-style port.
// Optional build macro: UART_BUS2MEM_ALIGN_CHK_EN rejects addresses with addr[1:0] != 0.
module uart_bus2mem #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h00000000
) (
    input  logic                  main_clk_i,
    input  logic                  main_rst_i,
    input  logic [1:0]            bus_trans_i,
    input  logic [31:0]           bus_addr_i,
    input  logic                  bus_write_i,
    input  logic [31:0]           bus_wdata_i,
    output logic                  bus_ready_o,
    output logic                  bus_resp_o,
    output logic [31:0]           bus_rdata_o,
    output logic                  mem_ena_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wena_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_err_i
);

    // Handshake: an address phase is taken on any clock edge where bus_ready_o=1
    // and bus_trans_i is NONSEQ or SEQ; the transfer completes on the next edge
    // with bus_ready_o=1, bus_resp_o then qualifying it as OKAY (0) or ERROR (1).

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    localparam logic [31:0] BASE = BASE_ADDR;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;

    logic addr_in_window;
    logic addr_aligned;
    logic addr_ok;
    logic accept;

    assign addr_in_window = (addr_q[31:ADDR_WIDTH+2] == BASE[31:ADDR_WIDTH+2]);

`ifdef UART_BUS2MEM_ALIGN_CHK_EN
    assign addr_aligned = (addr_q[1:0] == 2'b00);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
    assign addr_aligned    = 1'b1;
`endif

    assign addr_ok = addr_in_window && addr_aligned;

    // Only NONSEQ (2) and SEQ (3) start a transfer; both have bit 1 set.
    assign accept = bus_trans_i[1];

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        bus_ready_o = 1'b1;
        bus_resp_o  = 1'b0;
        bus_rdata_o = 32'h0;
        mem_ena_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wena_o  = 1'b0;
        mem_wdata_o = 32'h0;

        case (state_q)
            ST_IDLE: begin
                bus_ready_o = 1'b1;
            end
            ST_ACC: begin
                bus_ready_o = 1'b0;
                if (addr_ok) begin
                    mem_ena_o   = 1'b1;
                    mem_addr_o  = addr_q[ADDR_WIDTH+1:2];
                    mem_wena_o  = write_q;
                    mem_wdata_o = bus_wdata_i;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_ERR1;
                end
            end
            ST_WAIT: begin
                // A memory error turns this cycle into the first error cycle.
                if (mem_err_i) begin
                    bus_ready_o = 1'b0;
                    bus_resp_o  = 1'b1;
                    state_d     = ST_ERR2;
                end else begin
                    bus_ready_o = 1'b1;
                    if (!write_q) begin
                        bus_rdata_o = mem_rdata_i;
                    end
                end
            end
            ST_ERR1: begin
                bus_ready_o = 1'b0;
                bus_resp_o  = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                bus_ready_o = 1'b1;
                bus_resp_o  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every ready-high cycle ends a transfer (or idles) and may open the next one.
        if (bus_ready_o) begin
            if (accept) begin
                addr_d  = bus_addr_i;
                write_d = bus_write_i;
                state_d = ST_ACC;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Reset cycles abort silently: idle-looking outputs, no memory strobe.
        if (main_rst_i) begin
            bus_ready_o = 1'b1;
            bus_resp_o  = 1'b0;
            bus_rdata_o = 32'h0;
            mem_ena_o   = 1'b0;
            mem_addr_o  = '0;
            mem_wena_o  = 1'b0;
            mem_wdata_o = 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_bus2mem.sv
// Directed bench for uart_bus2mem: each task drives one scenario and checks outputs mid-cycle.
module tb_uart_bus2mem;

    localparam int AW = 13;

    logic          clk;
    logic          rst;
    logic [1:0]    bus_trans_i;
    logic [31:0]   bus_addr_i;
    logic          bus_write_i;
    logic [31:0]   bus_wdata_i;
    logic          bus_ready_o;
    logic          bus_resp_o;
    logic [31:0]   bus_rdata_o;
    logic          mem_ena_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wena_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_err_i;

    int checks;
    int failures;

    uart_bus2mem #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (32'h00000000)
    ) dut (
        .main_clk_i (clk),
        .main_rst_i (rst),
        .bus_trans_i(bus_trans_i),
        .bus_addr_i (bus_addr_i),
        .bus_write_i(bus_write_i),
        .bus_wdata_i(bus_wdata_i),
        .bus_ready_o(bus_ready_o),
        .bus_resp_o (bus_resp_o),
        .bus_rdata_o(bus_rdata_o),
        .mem_ena_o  (mem_ena_o),
        .mem_addr_o (mem_addr_o),
        .mem_wena_o (mem_wena_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_err_i  (mem_err_i)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        bus_trans_i = trans;
        bus_addr_i  = addr;
        bus_write_i = wr;
    endtask

    task automatic drive_idle();
        bus_trans_i = 2'd0;
        bus_addr_i  = 32'h0;
        bus_write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus_wdata_i = 32'h0;
        mem_rdata_i = 32'h0;
        mem_err_i   = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%h exp=1", bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b0) begin failures++; $display("FAIL rst_resp got=%h exp=0", bus_resp_o); end
        checks++; if (bus_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus_rdata_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL rst_ena got=%h exp=0", mem_ena_o); end
        checks++; if (mem_wena_o !== 1'b0) begin failures++; $display("FAIL rst_wena got=%h exp=0", mem_wena_o); end
        checks++; if (mem_addr_o !== 13'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata_o); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%h exp=1", bus_ready_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL post_rst_ena got=%h exp=0", mem_ena_o); end
    endtask

    task automatic test_idle_busy();
        cyc();
        drive_addr(2'd1, 32'h0000_0010, 1'b1);
        cyc();
        drive_addr(2'd0, 32'h0000_0010, 1'b1);
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL busy_ready got=%h exp=1", bus_ready_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL busy_ena got=%h exp=0", mem_ena_o); end
        drive_idle();
    endtask

    task automatic test_write();
        cyc();
        drive_addr(2'd2, 32'h0000_0010, 1'b1);
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL wr_addr_ready got=%h exp=1", bus_ready_o); end
        cyc();
        drive_idle();
        bus_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1) begin failures++; $display("FAIL wr_acc_ena got=%h exp=1", mem_ena_o); end
        checks++; if (mem_wena_o !== 1'b1) begin failures++; $display("FAIL wr_acc_wena got=%h exp=1", mem_wena_o); end
        checks++; if (mem_addr_o !== 13'h004) begin failures++; $display("FAIL wr_acc_addr got=%h exp=004", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_acc_wdata got=%h exp=cafef00d", mem_wdata_o); end
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL wr_acc_ready got=%h exp=0", bus_ready_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL wr_wait_ready got=%h exp=1", bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b0) begin failures++; $display("FAIL wr_wait_resp got=%h exp=0", bus_resp_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL wr_wait_ena got=%h exp=0", mem_ena_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL wr_wait_wdata got=%h exp=0", mem_wdata_o); end
        bus_wdata_i = 32'h0;
    endtask

    task automatic test_read();
        cyc();
        drive_addr(2'd2, 32'h0000_7FFC, 1'b0);
        cyc();
        drive_idle();
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1) begin failures++; $display("FAIL rd_acc_ena got=%h exp=1", mem_ena_o); end
        checks++; if (mem_wena_o !== 1'b0) begin failures++; $display("FAIL rd_acc_wena got=%h exp=0", mem_wena_o); end
        checks++; if (mem_addr_o !== 13'h1FFF) begin failures++; $display("FAIL rd_acc_addr got=%h exp=1fff", mem_addr_o); end
        cyc();
        mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (bus_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL rd_wait_rdata got=%h exp=12345678", bus_rdata_o); end
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL rd_wait_ready got=%h exp=1", bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b0) begin failures++; $display("FAIL rd_wait_resp got=%h exp=0", bus_resp_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_rdata_o !== 32'h0) begin failures++; $display("FAIL rd_idle_rdata got=%h exp=0", bus_rdata_o); end
        mem_rdata_i = 32'h0;
    endtask

    task automatic test_addr_err(input logic [31:0] addr);
        cyc();
        drive_addr(2'd2, addr, 1'b0);
        cyc();
        drive_idle();
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL aerr_acc_ena addr=%h got=%h exp=0", addr, mem_ena_o); end
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL aerr_acc_ready addr=%h got=%h exp=0", addr, bus_ready_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL aerr_e1_ready addr=%h got=%h exp=0", addr, bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b1) begin failures++; $display("FAIL aerr_e1_resp addr=%h got=%h exp=1", addr, bus_resp_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL aerr_e1_ena addr=%h got=%h exp=0", addr, mem_ena_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL aerr_e2_ready addr=%h got=%h exp=1", addr, bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b1) begin failures++; $display("FAIL aerr_e2_resp addr=%h got=%h exp=1", addr, bus_resp_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_resp_o !== 1'b0) begin failures++; $display("FAIL aerr_idle_resp addr=%h got=%h exp=0", addr, bus_resp_o); end
    endtask

    task automatic test_back_to_back();
        cyc();
        drive_addr(2'd2, 32'h0000_0000, 1'b1);
        cyc();
        drive_idle();
        bus_wdata_i = 32'hA5A5_0001;
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1 || mem_addr_o !== 13'h000) begin failures++; $display("FAIL b2b_acc1 ena=%h addr=%h exp ena=1 addr=000", mem_ena_o, mem_addr_o); end
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_acc1_ready got=%h exp=0", bus_ready_o); end
        cyc();
        drive_addr(2'd3, 32'h0000_0004, 1'b1);
        bus_wdata_i = 32'h0;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_wait1_ready got=%h exp=1", bus_ready_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL b2b_wait1_ena got=%h exp=0", mem_ena_o); end
        cyc();
        drive_idle();
        bus_wdata_i = 32'h5A5A_0002;
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1 || mem_addr_o !== 13'h001) begin failures++; $display("FAIL b2b_acc2 ena=%h addr=%h exp ena=1 addr=001", mem_ena_o, mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h5A5A_0002) begin failures++; $display("FAIL b2b_acc2_wdata got=%h exp=5a5a0002", mem_wdata_o); end
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_acc2_ready got=%h exp=0", bus_ready_o); end
        cyc();
        bus_wdata_i = 32'h0;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1 || bus_resp_o !== 1'b0) begin failures++; $display("FAIL b2b_wait2 ready=%h resp=%h exp ready=1 resp=0", bus_ready_o, bus_resp_o); end
    endtask

    task automatic test_mem_err();
        cyc();
        drive_addr(2'd2, 32'h0000_0008, 1'b0);
        cyc();
        drive_idle();
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1 || mem_addr_o !== 13'h002) begin failures++; $display("FAIL merr_acc ena=%h addr=%h exp ena=1 addr=002", mem_ena_o, mem_addr_o); end
        cyc();
        mem_err_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b0) begin failures++; $display("FAIL merr_e1_ready got=%h exp=0", bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b1) begin failures++; $display("FAIL merr_e1_resp got=%h exp=1", bus_resp_o); end
        checks++; if (bus_rdata_o !== 32'h0) begin failures++; $display("FAIL merr_e1_rdata got=%h exp=0", bus_rdata_o); end
        cyc();
        mem_err_i = 1'b0;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL merr_e2_ready got=%h exp=1", bus_ready_o); end
        checks++; if (bus_resp_o !== 1'b1) begin failures++; $display("FAIL merr_e2_resp got=%h exp=1", bus_resp_o); end
        checks++; if (bus_rdata_o !== 32'h0) begin failures++; $display("FAIL merr_e2_rdata got=%h exp=0", bus_rdata_o); end
        mem_rdata_i = 32'h0;
    endtask

    task automatic test_reset_in_acc();
        cyc();
        drive_addr(2'd2, 32'h0000_0020, 1'b1);
        cyc();
        drive_idle();
        bus_wdata_i = 32'h55AA_55AA;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL racc_ena got=%h exp=0", mem_ena_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL racc_wdata got=%h exp=0", mem_wdata_o); end
        checks++; if (bus_ready_o !== 1'b1 || bus_resp_o !== 1'b0) begin failures++; $display("FAIL racc_bus ready=%h resp=%h exp ready=1 resp=0", bus_ready_o, bus_resp_o); end
        cyc();
        rst = 1'b0;
        bus_wdata_i = 32'h0;
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1) begin failures++; $display("FAIL racc_idle_ready got=%h exp=1", bus_ready_o); end
        checks++; if (mem_ena_o !== 1'b0) begin failures++; $display("FAIL racc_idle_ena got=%h exp=0", mem_ena_o); end
        checks++; if (bus_resp_o !== 1'b0) begin failures++; $display("FAIL racc_idle_resp got=%h exp=0", bus_resp_o); end
    endtask

    task automatic test_misaligned();
`ifdef UART_BUS2MEM_ALIGN_CHK_EN
        test_addr_err(32'h0000_0002);
`else
        cyc();
        drive_addr(2'd2, 32'h0000_0002, 1'b0);
        cyc();
        drive_idle();
        @(negedge clk);
        checks++; if (mem_ena_o !== 1'b1 || mem_addr_o !== 13'h000) begin failures++; $display("FAIL misal_acc ena=%h addr=%h exp ena=1 addr=000", mem_ena_o, mem_addr_o); end
        cyc();
        @(negedge clk);
        checks++; if (bus_ready_o !== 1'b1 || bus_resp_o !== 1'b0) begin failures++; $display("FAIL misal_wait ready=%h resp=%h exp ready=1 resp=0", bus_ready_o, bus_resp_o); end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_idle_busy();
        test_write();
        test_read();
        test_addr_err(32'h0001_0000);
        test_addr_err(32'h0000_8000);
        test_back_to_back();
        test_mem_err();
        test_reset_in_acc();
        test_misaligned();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
